// File: rtl/multiplier_arb_pkg.sv
// Shared constants and FSM state encoding for the multiplier arbiter slice.
package multiplier_arb_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_BUSY = 2'd1;
    localparam arb_state_t ST_GAP  = 2'd2;

    function automatic int unsigned wd_width(input int unsigned timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active requester after last_grant.
module rr_arbiter
    import multiplier_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_valid
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CW    = IDX_W + 1;

    // One extra bit so last_grant+offset never overflows before the wrap.
    logic [CW-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = {1'b0, last_grant} + CW'(off);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!grant_valid && req_valid[cand[IDX_W-1:0]]) begin
                grant_valid               = 1'b1;
                grant_idx                 = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one multiplier between N_REQ requesters: round-robin grant, start
// handshake, product return and a watchdog that aborts hung jobs.
module multiplier_arbiter
    import multiplier_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        resp_done,
    output logic [N_REQ-1:0]        resp_err,
    output logic [2*DATA_W-1:0]     resp_product,
    output logic                    busy,
    output logic                    mul_start_sig,
    output logic [DATA_W-1:0]       mul_multiplicand,
    output logic [DATA_W-1:0]       mul_multiplier,
    input  logic                    mul_done_sig,
    input  logic [2*DATA_W-1:0]     mul_product
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned WD_W  = wd_width(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [WD_W-1:0]  WD_TERM  = WD_W'(TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [N_REQ-1:0]    req_ack_q, req_ack_d;
    logic [N_REQ-1:0]    resp_done_q, resp_done_d;
    logic [N_REQ-1:0]    resp_err_q, resp_err_d;
    logic [2*DATA_W-1:0] resp_product_q, resp_product_d;
    logic                busy_q, busy_d;
    logic                mul_start_q, mul_start_d;
    logic [DATA_W-1:0]   mul_a_q, mul_a_d;
    logic [DATA_W-1:0]   mul_b_q, mul_b_d;

    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic [N_REQ-1:0]    owner_oh;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req_valid   (req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // last_grant doubles as the owner of the job in flight.
    assign owner_oh = N_REQ'(1) << last_grant_q;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        wd_d           = wd_q;
        req_ack_d      = '0;
        resp_done_d    = '0;
        resp_err_d     = '0;
        resp_product_d = resp_product_q;
        mul_start_d    = mul_start_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d      = ST_BUSY;
                    last_grant_d = grant_idx;
                    req_ack_d    = grant;
                    mul_start_d  = 1'b1;
                    wd_d         = '0;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (grant[i]) begin
                            mul_a_d = req_a[i*DATA_W +: DATA_W];
                            mul_b_d = req_b[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done_sig) begin
                    state_d        = ST_GAP;
                    resp_product_d = mul_product;
                    resp_done_d    = owner_oh;
                    mul_start_d    = 1'b0;
                    wd_d           = '0;
                end else if (wd_q == WD_TERM) begin
                    state_d     = ST_GAP;
                    resp_err_d  = owner_oh;
                    mul_start_d = 1'b0;
                    wd_d        = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                mul_start_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= LAST_RST;
            wd_q           <= '0;
            req_ack_q      <= '0;
            resp_done_q    <= '0;
            resp_err_q     <= '0;
            resp_product_q <= '0;
            busy_q         <= 1'b0;
            mul_start_q    <= 1'b0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            wd_q           <= wd_d;
            req_ack_q      <= req_ack_d;
            resp_done_q    <= resp_done_d;
            resp_err_q     <= resp_err_d;
            resp_product_q <= resp_product_d;
            busy_q         <= busy_d;
            mul_start_q    <= mul_start_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
        end
    end

    assign req_ack          = req_ack_q;
    assign resp_done        = resp_done_q;
    assign resp_err         = resp_err_q;
    assign resp_product     = resp_product_q;
    assign busy             = busy_q;
    assign mul_start_sig    = mul_start_q;
    assign mul_multiplicand = mul_a_q;
    assign mul_multiplier   = mul_b_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Randomized bench for multiplier_arbiter against a transaction-level reference.
module tb_multiplier_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a, req_b;
    logic [N-1:0]    req_ack, resp_done, resp_err;
    logic [2*W-1:0]  resp_product;
    logic            busy, mul_start_sig, mul_done_sig;
    logic [W-1:0]    mul_multiplicand, mul_multiplier;
    logic [2*W-1:0]  mul_product;

    always #5 clk = ~clk;

    multiplier_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ack          (req_ack),
        .resp_done        (resp_done),
        .resp_err         (resp_err),
        .resp_product     (resp_product),
        .busy             (busy),
        .mul_start_sig    (mul_start_sig),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_done_sig     (mul_done_sig),
        .mul_product      (mul_product)
    );

    // Multiplier model: done after m_lat cycles of start, or never when hung.
    int m_lat  = 3;
    bit m_hang = 1'b0;
    int m_cnt  = 0;
    int m_spur = 0;

    always @(negedge clk) begin
        if (m_spur > 0) begin
            mul_done_sig = 1'b1;
            mul_product  = 16'($urandom);
            m_spur--;
        end else if (mul_start_sig && !m_hang) begin
            m_cnt++;
            mul_done_sig = (m_cnt == m_lat);
            mul_product  = (m_cnt == m_lat) ? 16'($signed(mul_multiplicand) * $signed(mul_multiplier))
                                             : 16'($urandom);
        end else begin
            m_cnt        = 0;
            mul_done_sig = 1'b0;
            mul_product  = 16'($urandom);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    int            ref_last = N - 1;
    logic [15:0]   ref_prod = '0;
    logic [N-1:0]  held     = '0;
    logic [N-1:0]  phantom  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int ref_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, ".ack"},   32'(req_ack), 32'd0);
        check_eq({tag, ".done"},  32'(resp_done), 32'd0);
        check_eq({tag, ".err"},   32'(resp_err), 32'd0);
        check_eq({tag, ".prod"},  32'(resp_product), 32'd0);
        check_eq({tag, ".busy"},  32'(busy), 32'd0);
        check_eq({tag, ".start"}, 32'(mul_start_sig), 32'd0);
        check_eq({tag, ".opa"},   32'(mul_multiplicand), 32'd0);
        check_eq({tag, ".opb"},   32'(mul_multiplier), 32'd0);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        held      = '0;
        phantom   = '0;
        req_valid = '0;
        #1;
        check_zero("rst");
        ref_last = N - 1;
        ref_prod = '0;
        tick();
        check_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Called in an IDLE cycle; new requesters get fresh random operands.
    task automatic add_reqs(input logic [N-1:0] nm);
        for (int i = 0; i < N; i++) begin
            if (nm[i] && !held[i]) set_ops(i, W'($urandom), W'($urandom));
        end
    endtask

    task automatic do_round(input logic [N-1:0] new_held, input int lat, input bit hang,
                            input bit keep, input bit do_phantom, input bit do_reset);
        int g;
        int resp_off;
        int p;
        logic [N-1:0] exp_oh;
        logic [W-1:0] ea, eb;
        held      = new_held;
        req_valid = held;
        m_lat     = lat;
        m_hang    = hang;
        g = ref_pick(held, ref_last);
        tick();
        if (g < 0) begin
            check_eq("noreq.ack", 32'(req_ack), 32'd0);
            check_eq("noreq.busy", 32'(busy), 32'd0);
            return;
        end
        exp_oh = N'(1) << g;
        ea = req_a[g*W +: W];
        eb = req_b[g*W +: W];
        check_eq("ack", 32'(req_ack), 32'(exp_oh));
        check_eq("ack.busy", 32'(busy), 32'd1);
        check_eq("ack.start", 32'(mul_start_sig), 32'd1);
        check_eq("ack.opa", 32'(mul_multiplicand), 32'(ea));
        check_eq("ack.opb", 32'(mul_multiplier), 32'(eb));
        ref_last = g;
        if (!keep) held[g] = 1'b0;
        if (do_phantom) phantom = ~held & N'($urandom);
        req_valid = held | phantom;
        if (do_reset) begin
            tick();
            reset_dut();
            return;
        end
        resp_off = hang ? TO : lat;
        for (int c = 1; c < resp_off; c++) begin
            tick();
            check_eq("busy.done", 32'(resp_done), 32'd0);
            check_eq("busy.err", 32'(resp_err), 32'd0);
            check_eq("busy.start", 32'(mul_start_sig), 32'd1);
            check_eq("busy.ack", 32'(req_ack), 32'd0);
        end
        tick();
        phantom   = '0;
        req_valid = held;
        if (hang) begin
            check_eq("to.err", 32'(resp_err), 32'(exp_oh));
            check_eq("to.done", 32'(resp_done), 32'd0);
        end else begin
            p = $signed(ea) * $signed(eb);
            ref_prod = p[15:0];
            check_eq("resp.done", 32'(resp_done), 32'(exp_oh));
            check_eq("resp.err", 32'(resp_err), 32'd0);
        end
        check_eq("resp.prod", 32'(resp_product), 32'(ref_prod));
        check_eq("gap.start", 32'(mul_start_sig), 32'd0);
        check_eq("gap.busy", 32'(busy), 32'd1);
        tick();
        check_eq("idle.busy", 32'(busy), 32'd0);
        check_eq("idle.ack", 32'(req_ack), 32'd0);
        check_eq("idle.done", 32'(resp_done), 32'd0);
        check_eq("idle.err", 32'(resp_err), 32'd0);
    endtask

    task automatic idle_round();
        held      = '0;
        phantom   = '0;
        req_valid = '0;
        m_spur    = 1;
        repeat (3) begin
            tick();
            check_eq("idl.ack", 32'(req_ack), 32'd0);
            check_eq("idl.done", 32'(resp_done), 32'd0);
            check_eq("idl.err", 32'(resp_err), 32'd0);
            check_eq("idl.busy", 32'(busy), 32'd0);
            check_eq("idl.prod", 32'(resp_product), 32'(ref_prod));
        end
    endtask

    initial begin
        logic [N-1:0] nm;
        int           sel;
        int           lat;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        mul_done_sig = 1'b0;
        mul_product  = '0;
        tick();
        reset_dut();

        set_ops(0, 8'd10, 8'd2);
        do_round(4'b0001, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        reset_dut();
        set_ops(0, 8'd10, 8'd2);
        set_ops(1, 8'd2, 8'd10);
        set_ops(2, 8'd11, 8'hFB);
        set_ops(3, 8'hFB, 8'hF5);
        held = 4'b1111;
        for (int r = 0; r < 4; r++) do_round(held, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        set_ops(0, 8'd7, 8'd3);
        set_ops(2, 8'hF0, 8'd5);
        for (int r = 0; r < 4; r++) do_round(4'b0101, 2, 1'b0, 1'b1, 1'b0, 1'b0);

        do_round(4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        do_round(4'b1000, TO, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_round();

        do_round(4'b0010, 5, 1'b0, 1'b1, 1'b0, 1'b1);
        set_ops(1, 8'd3, 8'd4);
        set_ops(3, 8'd5, 8'd6);
        do_round(4'b1010, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 80; r++) begin
            sel = $urandom_range(0, 99);
            if (sel < 8) begin
                idle_round();
            end else begin
                nm = held | N'($urandom);
                add_reqs(nm);
                lat = $urandom_range(1, TO);
                do_round(nm, lat, (sel >= 8 && sel < 22), 1'($urandom), ($urandom_range(0, 2) == 0),
                         (sel >= 22 && sel < 28 && lat >= 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
